// File: rtl/vector_pkg.sv
// vector_pkg: shared beat count, register/op widths and FSM encoding for the vector issue sequencer
package vector_pkg;
  localparam int BEATS = 4;
  localparam int IDX_W = $clog2(BEATS);
  localparam int REG_W = 3;
  localparam int NREG = 1 << REG_W;
  localparam int OP_W = 4;
  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;
endpackage

// File: rtl/vector_scoreboard.sv
// vector_scoreboard: per-register busy bits and RAW/WAW hazard detect (compiled only with VSEQ_SCOREBOARD_EN)
module vector_scoreboard import vector_pkg::*; (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_en,
  input  logic [REG_W-1:0] set_vd,
  input  logic             clr_en,
  input  logic [REG_W-1:0] clr_vd,
  input  logic             chk_en,
  input  logic [REG_W-1:0] vs1,
  input  logic [REG_W-1:0] vs2,
  input  logic [REG_W-1:0] vd,
  output logic [NREG-1:0]  busy,
  output logic             hazard
);
`ifdef VSEQ_SCOREBOARD_EN
  logic [NREG-1:0] set_mask, clr_mask;
  assign set_mask = set_en ? NREG'(1) << set_vd : '0;
  assign clr_mask = clr_en ? NREG'(1) << clr_vd : '0;
  // set is applied after clear so a same-cycle set wins
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) busy <= '0;
    else busy <= (busy & ~clr_mask) | set_mask;
  assign hazard = chk_en && (busy[vs1] || busy[vs2] || busy[vd]);
`else
  logic unused;
  assign unused = ^{clk, rst_n, set_en, set_vd, clr_en, clr_vd, chk_en, vs1, vs2, vd};
  assign busy = '0;
  assign hazard = 1'b0;
`endif
endmodule

// File: rtl/vector_issue_sequencer.sv
// vector_issue_sequencer: splits each vector instruction into 4 element beats with memory grant gating
// Optional register scoreboard hazard blocking enabled by VSEQ_SCOREBOARD_EN.
module vector_issue_sequencer import vector_pkg::*; (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_alu_op,
  input  logic [REG_W-1:0] in_vd,
  input  logic [REG_W-1:0] in_vs1,
  input  logic [REG_W-1:0] in_vs2,
  input  logic             in_reg_write,
  input  logic             in_mem_read,
  input  logic             in_mem_write,
  input  logic             in_tipo,
  output logic             beat_valid,
  input  logic             ex_ready,
  output logic [OP_W-1:0]  beat_alu_op,
  output logic [REG_W-1:0] beat_vd,
  output logic [IDX_W-1:0] beat_idx,
  output logic             beat_last,
  output logic             beat_reg_write,
  output logic             mem_req,
  output logic             mem_we,
  input  logic             mem_gnt,
  input  logic             wb_valid,
  input  logic [REG_W-1:0] wb_vd,
  output logic [NREG-1:0]  busy
);
  state_t state, state_nx;
  logic mem_read, mem_write, hazard, start, xfer;
  assign in_ready = (state == IDLE) && !hazard;
  assign start = in_valid && in_ready && in_tipo;
  assign beat_valid = (state == ISSUE);
  assign mem_req = beat_valid && (mem_read || mem_write);
  assign mem_we = mem_req && mem_write;
  assign xfer = beat_valid && ex_ready && (!mem_req || mem_gnt);
  assign beat_last = beat_valid && (beat_idx == IDX_W'(BEATS - 1));
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = start ? ISSUE : IDLE;
    else state_nx = (xfer && beat_last) ? IDLE : ISSUE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      beat_alu_op <= '0;
      beat_vd <= '0;
      beat_idx <= '0;
      beat_reg_write <= 1'b0;
      mem_read <= 1'b0;
      mem_write <= 1'b0;
    end else if (start) begin
      beat_alu_op <= in_alu_op;
      beat_vd <= in_vd;
      beat_idx <= '0;
      beat_reg_write <= in_reg_write;
      mem_read <= in_mem_read;
      mem_write <= in_mem_write;
    end else if (xfer) beat_idx <= beat_idx + 1'b1;
  vector_scoreboard u_sb (
    .clk(clk),
    .rst_n(rst_n),
    .set_en(start && in_reg_write),
    .set_vd(in_vd),
    .clr_en(wb_valid),
    .clr_vd(wb_vd),
    .chk_en(in_tipo),
    .vs1(in_vs1),
    .vs2(in_vs2),
    .vd(in_vd),
    .busy(busy),
    .hazard(hazard)
  );
endmodule

// File: tb/tb_vector_issue_sequencer.sv
// tb_vector_issue_sequencer: directed steps with a beat scoreboard queue for vector_issue_sequencer
module tb_vector_issue_sequencer;
`ifdef VSEQ_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready;
  logic [3:0] in_alu_op = '0;
  logic [2:0] in_vd = '0, in_vs1 = '0, in_vs2 = '0, wb_vd = '0, beat_vd;
  logic in_reg_write = 1'b0, in_mem_read = 1'b0, in_mem_write = 1'b0, in_tipo = 1'b0;
  logic beat_valid, ex_ready = 1'b1, beat_last, beat_reg_write;
  logic [3:0] beat_alu_op;
  logic [1:0] beat_idx;
  logic mem_req, mem_we, mem_gnt = 1'b1, wb_valid = 1'b0;
  logic [7:0] busy, mbusy = '0;
  logic [10:0] q[$];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  vector_issue_sequencer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_op(in_alu_op), .in_vd(in_vd), .in_vs1(in_vs1), .in_vs2(in_vs2),
    .in_reg_write(in_reg_write), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .in_tipo(in_tipo), .beat_valid(beat_valid), .ex_ready(ex_ready),
    .beat_alu_op(beat_alu_op), .beat_vd(beat_vd), .beat_idx(beat_idx),
    .beat_last(beat_last), .beat_reg_write(beat_reg_write), .mem_req(mem_req),
    .mem_we(mem_we), .mem_gnt(mem_gnt), .wb_valid(wb_valid), .wb_vd(wb_vd), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_instr(input logic [3:0] op, input logic [2:0] vd, input logic [2:0] vs1,
                           input logic [2:0] vs2, input logic rw, input logic mr,
                           input logic mw, input logic tipo);
    in_alu_op = op; in_vd = vd; in_vs1 = vs1; in_vs2 = vs2;
    in_reg_write = rw; in_mem_read = mr; in_mem_write = mw; in_tipo = tipo;
  endtask

  task automatic push_beats(input logic [3:0] op, input logic [2:0] vd, input logic rw);
    for (int i = 0; i < 4; i++) q.push_back({op, vd, 2'(i), i == 3, rw});
  endtask

  task automatic cyc();
    logic [10:0] e;
    if (beat_valid && ex_ready && (!mem_req || mem_gnt)) begin
      if (q.size() == 0) chk("unexpected_beat", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        chk("beat", {21'd0, beat_alu_op, beat_vd, beat_idx, beat_last, beat_reg_write}, {21'd0, e});
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && q.size() != 0; i++) cyc();
    chk("drain_left", q.size(), 0);
    chk("idle_after_drain", beat_valid, 1'b0);
  endtask

  initial begin
    #12;
    chk("rst_beat_valid", beat_valid, 1'b0);
    chk("rst_busy", busy, 8'h00);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_idx", beat_idx, 2'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", in_ready, 1'b1);
    // ADDV: four back-to-back beats, idx 0..3
    set_instr(4'h1, 3'd2, 3'd0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b1;
    chk("addv_ready", in_ready, 1'b1);
    push_beats(4'h1, 3'd2, 1'b1);
    cyc();
    in_valid = 1'b0;
    if (SB) mbusy[2] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("addv_valid", beat_valid, 1'b1);
      chk("addv_idx", beat_idx, i);
      cyc();
    end
    chk("addv_done", beat_valid, 1'b0);
    chk("addv_busy", busy, mbusy);
    set_instr(4'h0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("addv_idle_ready", in_ready, 1'b1);
    // LOADV with grant withheld at idx 1
    set_instr(4'h3, 3'd3, 3'd4, 3'd5, 1'b1, 1'b1, 1'b0, 1'b1);
    in_valid = 1'b1;
    push_beats(4'h3, 3'd3, 1'b1);
    cyc();
    in_valid = 1'b0;
    if (SB) mbusy[3] = 1'b1;
    chk("ld_mem_req", mem_req, 1'b1);
    chk("ld_mem_we", mem_we, 1'b0);
    cyc();
    mem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("ld_stall_idx", beat_idx, 2'd1);
      chk("ld_stall_req", mem_req, 1'b1);
      cyc();
    end
    chk("ld_held_idx", beat_idx, 2'd1);
    mem_gnt = 1'b1;
    drain(20);
    chk("ld_busy", busy, mbusy);
    // STOREV
    set_instr(4'h4, 3'd7, 3'd0, 3'd1, 1'b0, 1'b0, 1'b1, 1'b1);
    in_valid = 1'b1;
    push_beats(4'h4, 3'd7, 1'b0);
    cyc();
    in_valid = 1'b0;
    chk("st_mem_we", mem_we, 1'b1);
    drain(20);
    // hazard on vs1=2, released by writeback
    set_instr(4'h1, 3'd6, 3'd2, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("haz_blocked", in_ready, !SB);
    wb_valid = 1'b1; wb_vd = 3'd2;
    cyc();
    wb_valid = 1'b0;
    mbusy[2] = 1'b0;
    chk("haz_released", in_ready, 1'b1);
    chk("haz_busy", busy, mbusy);
    in_valid = 1'b1;
    push_beats(4'h1, 3'd6, 1'b1);
    cyc();
    in_valid = 1'b0;
    if (SB) mbusy[6] = 1'b1;
    drain(20);
    chk("haz_busy_after", busy, mbusy);
    // set beats clear on the same register
    set_instr(4'h2, 3'd5, 3'd0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1);
    wb_valid = 1'b1; wb_vd = 3'd5;
    in_valid = 1'b1;
    push_beats(4'h2, 3'd5, 1'b1);
    cyc();
    in_valid = 1'b0; wb_valid = 1'b0;
    if (SB) mbusy[5] = 1'b1;
    chk("setwin_busy", busy, mbusy);
    drain(20);
    // tipo=0 is accepted and dropped
    set_instr(4'h9, 3'd0, 3'd7, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("scalar_ready", in_ready, 1'b1);
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("scalar_no_beat", beat_valid, 1'b0);
    chk("scalar_busy", busy, mbusy);
    chk("scalar_idle", in_ready, 1'b1);
    cyc();
    chk("scalar_no_beat2", beat_valid, 1'b0);
    // async reset in the middle of an instruction
    set_instr(4'h5, 3'd1, 3'd0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b1;
    push_beats(4'h5, 3'd1, 1'b1);
    cyc();
    in_valid = 1'b0;
    cyc();
    cyc();
    chk("mid_idx", beat_idx, 2'd2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", beat_valid, 1'b0);
    chk("mid_rst_busy", busy, 8'h00);
    chk("mid_rst_idx", beat_idx, 2'd0);
    chk("mid_rst_last", beat_last, 1'b0);
    chk("mid_rst_req", mem_req, 1'b0);
    chk("mid_rst_alu", beat_alu_op, 4'h0);
    q.delete();
    mbusy = '0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_mid_ready", in_ready, 1'b1);
    set_instr(4'h6, 3'd1, 3'd2, 3'd3, 1'b0, 1'b1, 1'b0, 1'b1);
    in_valid = 1'b1;
    push_beats(4'h6, 3'd1, 1'b0);
    cyc();
    in_valid = 1'b0;
    ex_ready = 1'b0;
    chk("post_idx0", beat_idx, 2'd0);
    chk("post_valid", beat_valid, 1'b1);
    cyc();
    cyc();
    chk("exstall_idx", beat_idx, 2'd0);
    ex_ready = 1'b1;
    drain(20);
    chk("final_busy", busy, mbusy);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
